vga_mode_seq: RTL

VGA_MODE_SEQ -- requirements
Module: vga_mode_seq

---
 rtl/vga_mode_seq_if.sv | 10 +
 rtl/vga_mode_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_mode_seq_if.sv
// Mode-change request handshake between a requester (master) and vga_mode_seq (slave).
// A transfer happens on any rising clk edge where req_valid && req_ready; req_mode is held stable while req_valid waits.
interface vga_mode_seq_if;
  logic req_valid;
  logic req_mode;
  logic req_ready;

  modport master (output req_valid, output req_mode, input req_ready);
  modport slave  (input req_valid, input req_mode, output req_ready);
endinterface

// File: rtl/vga_mode_seq.sv
// Sequences an RGB/YPbPr colour-converter mode switch behind blanked frames, stepping on vsync rises.
// Optional vsync watchdog compiled in with `define VGA_MODE_SEQ_WATCHDOG_EN.
module vga_mode_seq #(
  parameter int BLANK_FRAMES  = 2,
  parameter bit YPBPR_DEFAULT = 1'b0,
  parameter int WD_CYCLES     = 2_000_000
) (
  input  logic                clk,
  input  logic                reset,
  vga_mode_seq_if.slave       req,
  input  logic                vsync,
  output logic                ypbpr_en,
  output logic                blank,
  output logic                busy,
`ifdef VGA_MODE_SEQ_WATCHDOG_EN
  output logic                wd_timeout,
`endif
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_BLANK1  = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15 || WD_CYCLES < 1) begin : g_param_check
    $error("vga_mode_seq: parameter out of range");
  end

  state_t     r_state, w_state_nx;
  logic       r_vsync_d;
  logic       r_target, w_target_nx;
  logic       r_ypbpr, w_ypbpr_nx;
  logic       r_blank, w_blank_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic       w_vs_rise;
  logic       w_step;
  logic       w_accept;

  assign w_vs_rise = vsync && !r_vsync_d;
  assign w_accept  = req.req_valid && req.req_ready;

`ifdef VGA_MODE_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_wd_to;
  logic            w_wd_fire;

  // A missing vsync is replaced by a synthetic rise once the count hits WD_CYCLES.
  assign w_wd_fire = (r_state != S_IDLE) && (r_wd_cnt == WD_W'(WD_CYCLES));
  assign w_step    = w_vs_rise || w_wd_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt <= '0;
      r_wd_to  <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_step) r_wd_cnt <= '0;
      else                             r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_fire) r_wd_to <= 1'b1;
    end
  end

  assign wd_timeout = r_wd_to;
`else
  assign w_step = w_vs_rise;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_vsync_d <= 1'b0;
      r_target  <= 1'b0;
      r_ypbpr   <= YPBPR_DEFAULT;
      r_blank   <= 1'b0;
      r_cnt     <= 4'd0;
    end else begin
      r_state   <= w_state_nx;
      r_vsync_d <= vsync;
      r_target  <= w_target_nx;
      r_ypbpr   <= w_ypbpr_nx;
      r_blank   <= w_blank_nx;
      r_cnt     <= w_cnt_nx;
    end
  end

  // A vsync rise in the accept cycle is ignored because IDLE never looks at w_step.
  always_comb begin
    w_state_nx  = r_state;
    w_target_nx = r_target;
    w_ypbpr_nx  = r_ypbpr;
    w_blank_nx  = r_blank;
    w_cnt_nx    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (req.req_mode != r_ypbpr)) begin
          w_target_nx = req.req_mode;
          w_state_nx  = S_WAIT_VS;
        end
      end
      S_WAIT_VS: begin
        if (w_step) begin
          w_blank_nx = 1'b1;
          w_state_nx = S_BLANK1;
        end
      end
      S_BLANK1: begin
        // One full frame of blank has passed, so the converter pipeline holds only zeros.
        if (w_step) begin
          w_ypbpr_nx = r_target;
          w_cnt_nx   = 4'(BLANK_FRAMES);
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_step) begin
          if (r_cnt <= 4'd1) begin
            w_cnt_nx   = 4'd0;
            w_blank_nx = 1'b0;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx = r_cnt - 4'd1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign req.req_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign ypbpr_en      = r_ypbpr;
  assign blank         = r_blank;
  assign o_dbg_state   = r_state;

endmodule
